ram_scan_arbiter: RTL

- Arbitrates a single-port 32x4 synchronous RAM between two requesters: a write requester (switch-driven data entry) and an internal periodic scanner that reads successive addresses for the 7-segment display path.
- Sits between the board I/O logic and the RAM, replacing the direct address multiplexing between read and write addresses.
- Provides a req/ack write handshake, fair alternation under contention, scan-address wrap-around, and a sticky overrun flag for missed scan ticks.

---
 rtl/ram_scan_arbiter_if.sv | 35 +++
 rtl/ram_scan_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/ram_scan_arbiter_if.sv
// Bus between the write requester / RAM / display path and the arbiter.
//
// Write handshake (req/ack): the requester raises wr_req and holds wr_req,
// wr_addr and wr_data stable until it observes wr_ack high for one cycle.
// wr_ack marks the cycle the write is presented to the RAM. wr_req may
// then be dropped or held for a further write. There is no back-pressure
// on the display side: rd_valid is a one-cycle strobe that is never stalled.
interface ram_scan_arbiter_if;
  logic       wr_req;
  logic [4:0] wr_addr;
  logic [3:0] wr_data;
  logic       wr_ack;
  logic [4:0] ram_addr;
  logic [3:0] ram_data;
  logic       ram_wren;
  logic [3:0] ram_q;
  logic [4:0] disp_addr;
  logic [3:0] disp_data;
  logic       rd_valid;
  logic       overrun;

  // Arbiter side
  modport slave (
    input  wr_req, wr_addr, wr_data, ram_q,
    output wr_ack, ram_addr, ram_data, ram_wren,
           disp_addr, disp_data, rd_valid, overrun
  );

  // Requester / RAM / display side
  modport master (
    output wr_req, wr_addr, wr_data, ram_q,
    input  wr_ack, ram_addr, ram_data, ram_wren,
           disp_addr, disp_data, rd_valid, overrun
  );
endinterface

// File: rtl/ram_scan_arbiter.sv
// Single-port 32x4 RAM arbiter: a switch-driven write requester shares the
// RAM with a periodic scanner that feeds the 7-segment display path.
// Contention alternates between the two; missed scan ticks set a sticky flag.
module ram_scan_arbiter #(
  parameter int unsigned TICK_DIV = 25000000
) (
  input  logic                clock,
  input  logic                resetn,
  input  logic                scan_en,
  ram_scan_arbiter_if.slave   bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    RD_WAIT = 2'd2,
    RD_CAP  = 2'd3
  } state_t;

  localparam logic [31:0] TICK_LAST = 32'(TICK_DIV - 1);

  state_t      state;
  state_t      state_next;
  logic [31:0] tick_cnt;
  logic        tick;
  logic        read_pend;
  logic        last_grant_wr;
  logic [4:0]  scan_addr;
  logic        grant_wr;
  logic        grant_rd;
  logic        rd_done;

  assign tick      = scan_en && (tick_cnt == TICK_LAST);
  assign dbg_state = state;

  // Free-running scan tick divider; holds its value while scan_en is low.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_cnt <= '0;
    end else if (scan_en) begin
      if (tick_cnt == TICK_LAST) tick_cnt <= '0;
      else                       tick_cnt <= tick_cnt + 32'd1;
    end
  end

  // Pending-read bookkeeping: ticks do not queue, a tick that finds a read
  // still pending is recorded as an overrun unless that read completes now.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      read_pend   <= 1'b0;
      bus.overrun <= 1'b0;
    end else if (tick) begin
      read_pend <= 1'b1;
      if (read_pend && !rd_done) bus.overrun <= 1'b1;
    end else if (rd_done) begin
      read_pend <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state and grant decisions; the loser of the last contention wins the next.
  always_comb begin
    state_next = state;
    grant_wr   = 1'b0;
    grant_rd   = 1'b0;
    rd_done    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wr_req && (!read_pend || !last_grant_wr)) begin
          grant_wr   = 1'b1;
          state_next = WRITE;
        end else if (read_pend) begin
          grant_rd   = 1'b1;
          state_next = RD_WAIT;
        end
      end
      WRITE:   state_next = IDLE;
      RD_WAIT: state_next = RD_CAP;
      RD_CAP: begin
        rd_done    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // RAM port, write acknowledge and display capture registers.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bus.ram_addr  <= '0;
      bus.ram_data  <= '0;
      bus.ram_wren  <= 1'b0;
      bus.wr_ack    <= 1'b0;
      bus.disp_addr <= '0;
      bus.disp_data <= '0;
      bus.rd_valid  <= 1'b0;
      scan_addr     <= '0;
      last_grant_wr <= 1'b0;
    end else begin
      bus.wr_ack   <= grant_wr;
      bus.ram_wren <= grant_wr;
      bus.rd_valid <= rd_done;
      if (grant_wr) begin
        bus.ram_addr  <= bus.wr_addr;
        bus.ram_data  <= bus.wr_data;
        last_grant_wr <= 1'b1;
      end else if (grant_rd) begin
        // ram_data keeps the last written value during reads
        bus.ram_addr  <= scan_addr;
        last_grant_wr <= 1'b0;
      end
      if (rd_done) begin
        bus.disp_data <= bus.ram_q;
        bus.disp_addr <= scan_addr;
        scan_addr     <= scan_addr + 5'd1;
      end
    end
  end

endmodule
